// File: rtl/timer_array_pkg.sv
// Shared register map constants for the memory-mapped timer array.
// Byte offsets within a channel window, CTRL bit positions and channel stride.
package timer_array_pkg;

  localparam logic [3:0] OFF_CNT  = 4'h0;
  localparam logic [3:0] OFF_LIM  = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h8;
  localparam logic [3:0] OFF_PRE  = 4'hC;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_READY    = 2;
  localparam int CTRL_OVERRUN  = 3;
  localparam int CTRL_IE       = 4;

  localparam int CH_STRIDE = 16;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CNT/LIM/CTRL/PRE registers, prescaler and terminal-count logic.
// Read data is combinational and zero unless rd_en; writes land on the clock edge; no backpressure.
// IE bit and irq_req exist only when TIMER_ARRAY_IRQ_EN is defined.
module timer_channel
  import timer_array_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int CNT_WIDTH = 32,
  parameter int PRE_WIDTH = 16,
  parameter int LIM_RESET = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [3:0]      reg_off,
  input  logic [BITS-1:0] wr_dat,
  output logic [BITS-1:0] rd_dat
`ifdef TIMER_ARRAY_IRQ_EN
  , output logic          irq_req
`endif
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, lim_q, lim_d;
  logic [PRE_WIDTH-1:0] pre_q, pre_d, psc_q, psc_d;
  logic en_q, en_d, per_q, per_d, rdy_q, rdy_d, ovr_q, ovr_d;
  logic ie_q, ie_d;
  logic wr_cnt, wr_lim, wr_ctrl, wr_pre;
  logic tick, terminal;
  logic [4:0] ctrl_v;

  always_comb begin
    wr_cnt  = wr_en && (reg_off == OFF_CNT);
    wr_lim  = wr_en && (reg_off == OFF_LIM);
    wr_ctrl = wr_en && (reg_off == OFF_CTRL);
    wr_pre  = wr_en && (reg_off == OFF_PRE);

    // A CNT/PRE write restarts the prescaler and swallows a coincident tick.
    tick     = en_q && (psc_q == pre_q) && !(wr_cnt || wr_pre);
    terminal = tick && (lim_q != '0) && (cnt_q >= lim_q - CNT_WIDTH'(1));

    psc_d = psc_q;
    if (wr_cnt || wr_pre) psc_d = '0;
    else if (en_q)        psc_d = (psc_q == pre_q) ? '0 : psc_q + PRE_WIDTH'(1);

    cnt_d = cnt_q;
    if (wr_cnt)        cnt_d = CNT_WIDTH'(wr_dat);
    else if (terminal) cnt_d = '0;
    else if (tick)     cnt_d = cnt_q + CNT_WIDTH'(1);

    lim_d = wr_lim ? CNT_WIDTH'(wr_dat) : lim_q;
    pre_d = wr_pre ? PRE_WIDTH'(wr_dat) : pre_q;

    en_d = en_q;
    if (terminal && !per_q) en_d = 1'b0;
    if (wr_ctrl)            en_d = wr_dat[CTRL_EN];
    per_d = wr_ctrl ? wr_dat[CTRL_PERIODIC] : per_q;

    // Sticky flags: software clears, hardware set in the same cycle wins.
    rdy_d = rdy_q;
    if (wr_ctrl && !wr_dat[CTRL_READY]) rdy_d = 1'b0;
    if (terminal)                       rdy_d = 1'b1;
    ovr_d = ovr_q;
    if (wr_ctrl && !wr_dat[CTRL_OVERRUN]) ovr_d = 1'b0;
    if (terminal && rdy_q)                ovr_d = 1'b1;

`ifdef TIMER_ARRAY_IRQ_EN
    ie_d = wr_ctrl ? wr_dat[CTRL_IE] : ie_q;
`else
    ie_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      lim_q <= CNT_WIDTH'(LIM_RESET);
      pre_q <= '0;
      psc_q <= '0;
      en_q  <= 1'b0;
      per_q <= 1'b0;
      rdy_q <= 1'b0;
      ovr_q <= 1'b0;
      ie_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      pre_q <= pre_d;
      psc_q <= psc_d;
      en_q  <= en_d;
      per_q <= per_d;
      rdy_q <= rdy_d;
      ovr_q <= ovr_d;
      ie_q  <= ie_d;
    end
  end

  always_comb begin
    ctrl_v = '0;
    ctrl_v[CTRL_EN]       = en_q;
    ctrl_v[CTRL_PERIODIC] = per_q;
    ctrl_v[CTRL_READY]    = rdy_q;
    ctrl_v[CTRL_OVERRUN]  = ovr_q;
    ctrl_v[CTRL_IE]       = ie_q;
    rd_dat = '0;
    if (rd_en) begin
      case (reg_off)
        OFF_CNT:  rd_dat = BITS'(cnt_q);
        OFF_LIM:  rd_dat = BITS'(lim_q);
        OFF_CTRL: rd_dat = BITS'(ctrl_v);
        OFF_PRE:  rd_dat = BITS'(pre_q);
        default:  rd_dat = '0;
      endcase
    end
  end

`ifdef TIMER_ARRAY_IRQ_EN
  assign irq_req = rdy_q && ie_q;
`endif

endmodule

// File: rtl/mmio_timer_array.sv
// NUM_CH memory-mapped timer channels on an OR-combined bus; same-cycle reads, registered writes,
// no backpressure. TIMER_ARRAY_IRQ_EN adds the registered irq output (OR of READY & IE).
module mmio_timer_array
  import timer_array_pkg::*;
#(
  parameter int              BITS      = 32,
  parameter int              NUM_CH    = 4,
  parameter int              CNT_WIDTH = 32,
  parameter int              PRE_WIDTH = 16,
  parameter logic [BITS-1:0] BASE      = 32'hF0000200,
  parameter int              LIM_RESET = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            re,
  input  logic [BITS-1:0] memAddr,
  input  logic [BITS-1:0] dataBusIn,
  output logic [BITS-1:0] dataBusOut
`ifdef TIMER_ARRAY_IRQ_EN
  , output logic          irq
`endif
);

  logic [BITS-1:0] offset;
  logic            hit;
  logic            rd_ok;
  logic [BITS-1:0] ch_rd [NUM_CH];

  always_comb begin
    offset = memAddr - BASE;
    hit    = (offset < BITS'(NUM_CH * CH_STRIDE)) && (offset[1:0] == 2'b00);
    rd_ok  = re && !we && !reset && hit;
  end

`ifdef TIMER_ARRAY_IRQ_EN
  logic [NUM_CH-1:0] irq_req;
  logic              irq_q, irq_d;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_sel;
    assign ch_sel = (offset[7:4] == 4'(i));
    timer_channel #(
      .BITS      (BITS),
      .CNT_WIDTH (CNT_WIDTH),
      .PRE_WIDTH (PRE_WIDTH),
      .LIM_RESET (LIM_RESET)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (we && hit && ch_sel),
      .rd_en   (rd_ok && ch_sel),
      .reg_off (offset[3:0]),
      .wr_dat  (dataBusIn),
      .rd_dat  (ch_rd[i])
`ifdef TIMER_ARRAY_IRQ_EN
      , .irq_req (irq_req[i])
`endif
    );
  end

  // Unselected channels return zero, so a plain OR is the read mux.
  always_comb begin
    dataBusOut = '0;
    for (int i = 0; i < NUM_CH; i++) dataBusOut = dataBusOut | ch_rd[i];
  end

`ifdef TIMER_ARRAY_IRQ_EN
  assign irq_d = |irq_req;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_mmio_timer_array.sv
// Directed bench for mmio_timer_array: reset register table plus timing sequences per channel.
// IRQ checks compile in only when TIMER_ARRAY_IRQ_EN is defined.
module tb_mmio_timer_array;

  localparam logic [31:0] B  = 32'hF0000200;
  localparam logic [31:0] C0 = B, C1 = B + 32'h10, C2 = B + 32'h20, C3 = B + 32'h30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0, re = 1'b0;
  logic [31:0] memAddr = '0, dataBusIn = '0;
  logic [31:0] dataBusOut;
`ifdef TIMER_ARRAY_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t tbl[20];

  mmio_timer_array dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .re         (re),
    .memAddr    (memAddr),
    .dataBusIn  (dataBusIn),
    .dataBusOut (dataBusOut)
`ifdef TIMER_ARRAY_IRQ_EN
    , .irq      (irq)
`endif
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    memAddr = a;
    re = 1'b1;
    #1;
    d = dataBusOut;
    re = 1'b0;
    memAddr = '0;
    check(name, d, exp);
  endtask

  // Call just after a falling edge: the write lands on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memAddr = a;
    dataBusIn = d;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    memAddr = '0;
    dataBusIn = '0;
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      tbl[4*c+0] = '{B + 32'(16*c) + 32'h0, 32'd0};
      tbl[4*c+1] = '{B + 32'(16*c) + 32'h4, 32'd1000};
      tbl[4*c+2] = '{B + 32'(16*c) + 32'h8, 32'd0};
      tbl[4*c+3] = '{B + 32'(16*c) + 32'hC, 32'd0};
    end
    tbl[16] = '{B + 32'h40, 32'd0};
    tbl[17] = '{B + 32'h2, 32'd0};
    tbl[18] = '{B - 32'h4, 32'd0};
    tbl[19] = '{32'h0, 32'd0};

    repeat (2) @(negedge clk);
    chk_rd("rd_in_reset", C0 + 32'h4, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) chk_rd($sformatf("reset_tbl[%0d]", i), tbl[i].addr, tbl[i].exp);
    @(negedge clk);

    // ch0 periodic, LIM=5, PRE=0
    wr(C0 + 32'h4, 32'd5);
    wr(C0 + 32'hC, 32'd0);
    wr(C0 + 32'h8, 32'h3);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk_rd($sformatf("ch0_cnt_%0d", k), C0, 32'(k));
    end
    @(negedge clk);
    chk_rd("ch0_wrap_cnt", C0, 32'd0);
    chk_rd("ch0_ready", C0 + 32'h8, 32'h7);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk_rd($sformatf("ch0_cnt2_%0d", k), C0, 32'(k % 5));
    end
    chk_rd("ch0_overrun", C0 + 32'h8, 32'hF);

    // Clear flags, then write CTRL exactly on the terminal tick
    wr(C0 + 32'h8, 32'h3);
    chk_rd("ch0_cleared", C0 + 32'h8, 32'h3);
    chk_rd("ch0_cnt_after_clr", C0, 32'd1);
    repeat (3) @(negedge clk);
    chk_rd("ch0_cnt_pre_term", C0, 32'd4);
    wr(C0 + 32'h8, 32'h3);
    chk_rd("ch0_set_wins", C0 + 32'h8, 32'h7);
    chk_rd("ch0_set_wins_cnt", C0, 32'd0);
    wr(C0 + 32'h8, 32'h0);
    chk_rd("ch0_sw_clear", C0 + 32'h8, 32'h0);

    // ch1 one-shot, PRE=3, LIM=2
    wr(C1 + 32'hC, 32'd3);
    wr(C1 + 32'h4, 32'd2);
    wr(C1 + 32'h8, 32'h1);
    chk_rd("ch1_cnt_start", C1, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk_rd($sformatf("ch1_pre_%0d", k), C1, 32'd0);
    end
    @(negedge clk);
    chk_rd("ch1_cnt_4cyc", C1, 32'd1);
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      chk_rd($sformatf("ch1_pre_%0d", k), C1, 32'd1);
    end
    @(negedge clk);
    chk_rd("ch1_term_cnt", C1, 32'd0);
    chk_rd("ch1_term_ctrl", C1 + 32'h8, 32'h4);
    repeat (10) @(negedge clk);
    chk_rd("ch1_hold_cnt", C1, 32'd0);
    chk_rd("ch1_hold_ctrl", C1 + 32'h8, 32'h4);

    wr(C1 + 32'h8, 32'h14);
`ifdef TIMER_ARRAY_IRQ_EN
    chk_rd("ch1_ie_rw", C1 + 32'h8, 32'h14);
    check("irq_not_yet", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_rise", {31'd0, irq}, 32'd1);
    wr(C1 + 32'h8, 32'h10);
    check("irq_still_high", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("irq_fall", {31'd0, irq}, 32'd0);
`else
    chk_rd("ch1_ie_ignored", C1 + 32'h8, 32'h4);
`endif

    // ch2 free-running wrap with LIM=0
    wr(C2 + 32'h4, 32'd0);
    wr(C2 + 32'h0, 32'hFFFF_FFFE);
    wr(C2 + 32'h8, 32'h3);
    chk_rd("ch2_cnt_fe", C2, 32'hFFFF_FFFE);
    @(negedge clk);
    chk_rd("ch2_cnt_ff", C2, 32'hFFFF_FFFF);
    @(negedge clk);
    chk_rd("ch2_cnt_wrap", C2, 32'd0);
    chk_rd("ch2_no_ready", C2 + 32'h8, 32'h3);
    wr(C2 + 32'h8, 32'h0);

    // LIM written below CNT fires on the next tick
    wr(C2 + 32'h0, 32'd10);
    wr(C2 + 32'h4, 32'd4);
    wr(C2 + 32'h8, 32'h3);
    chk_rd("ch2_lim_below_cnt", C2, 32'd10);
    @(negedge clk);
    chk_rd("ch2_lim_below_term", C2, 32'd0);
    chk_rd("ch2_lim_below_rdy", C2 + 32'h8, 32'h7);
    wr(C2 + 32'h8, 32'h0);

    for (int i = 12; i < 16; i++) chk_rd($sformatf("ch3_untouched[%0d]", i), tbl[i].addr, tbl[i].exp);

    // Asynchronous reset mid-count with no clock edge while asserted
    @(negedge clk);
    wr(C0 + 32'h8, 32'h3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    chk_rd("arst_cnt0", C0, 32'd0);
    chk_rd("arst_lim0", C0 + 32'h4, 32'd1000);
    chk_rd("arst_ctrl0", C0 + 32'h8, 32'd0);
    chk_rd("arst_pre1", C1 + 32'hC, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
